core_run_ctrl: RTL and testbench

- Run/step sequencer and memory-port arbiter for the 8-phase accumulator core.
- Generates the 3-bit phase that the instruction controller decodes, plus a core clock-enable.
- Freezes the core on halt or on memory wait states.
- Shares the single-port memory between the core and a debug/loader port; the loader is granted only at instruction boundaries.

---
 rtl/core_run_ctrl_if.sv | 40 ++++
 rtl/core_run_ctrl.sv | 151 +++++++++++++++
 tb/tb_core_run_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/core_run_ctrl_if.sv
// Memory-port bundle of core_run_ctrl: core strobes, debug/loader handshake and the shared memory port.
// The slave modport is the controller side; the master modport is the environment.
interface core_run_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
);
    logic                  cpu_rd;
    logic                  cpu_wr;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  dbg_req;
    logic                  dbg_wr;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic                  dbg_gnt;
    logic                  dbg_ack;
    logic [DATA_WIDTH-1:0] dbg_rdata;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        input  mem_ready, mem_rdata,
        output dbg_gnt, dbg_ack, dbg_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        output mem_ready, mem_rdata,
        input  dbg_gnt, dbg_ack, dbg_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/core_run_ctrl.sv
// Run/step sequencer and memory-port arbiter for the 8-phase accumulator core.
// Optional instruction counter output instr_cnt: define CORE_RUN_CTRL_INSTR_CNT_EN.
module core_run_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            step,
    input  logic            stop,
    input  logic            core_halt,
    core_run_ctrl_if.slave  bus,
    output logic [2:0]      phase,
    output logic            cpu_en,
    output logic [2:0]      run_state
`ifdef CORE_RUN_CTRL_INSTR_CNT_EN
    ,
    output logic [15:0]     instr_cnt
`endif
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        HALTED = 3'd3,
        DBG    = 3'd4
    } state_t;

    state_t                state, state_nxt, ret_state, ret_nxt;
    logic [2:0]            phase_nxt;
    logic                  ack_done, ack_done_nxt, dbg_ack_q;
    logic                  stall, boundary, dbg_hit;
    logic [DATA_WIDTH-1:0] rdata_q, wdata_mux;
    logic [ADDR_WIDTH-1:0] addr_mux;

    assign stall     = (bus.cpu_rd | bus.cpu_wr) & ~bus.mem_ready;
    assign cpu_en    = ((state == RUN) || (state == STEP)) && !stall;
    assign boundary  = cpu_en && (phase == 3'd7);
    // Loader access completes on the first ready cycle; ack_done masks the strobes afterwards.
    assign dbg_hit   = (state == DBG) && !ack_done && bus.mem_ready;
    assign run_state = state;
    assign bus.dbg_ack   = dbg_ack_q;
    assign bus.dbg_rdata = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ret_state <= IDLE;
            phase     <= 3'd0;
            ack_done  <= 1'b0;
            dbg_ack_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            phase     <= phase_nxt;
            ack_done  <= ack_done_nxt;
            dbg_ack_q <= dbg_hit;
            if (dbg_hit && !bus.dbg_wr)
                rdata_q <= bus.mem_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        ret_nxt   = ret_state;
        phase_nxt = phase;
        // The halt edge is still enabled for the core, but the phase must freeze on it.
        if (cpu_en && !core_halt)
            phase_nxt = phase + 3'd1;
        case (state)
            IDLE: begin
                if (bus.dbg_req) begin
                    state_nxt = DBG;
                    ret_nxt   = IDLE;
                end else if (start) begin
                    state_nxt = RUN;
                end else if (step) begin
                    state_nxt = STEP;
                end
            end
            RUN: begin
                if (core_halt && cpu_en) begin
                    state_nxt = HALTED;
                end else if (boundary && bus.dbg_req) begin
                    state_nxt = DBG;
                    ret_nxt   = stop ? IDLE : RUN;
                end else if (boundary && stop) begin
                    state_nxt = IDLE;
                end
            end
            STEP: begin
                if (core_halt && cpu_en)
                    state_nxt = HALTED;
                else if (boundary)
                    state_nxt = IDLE;
            end
            HALTED: begin
                if (bus.dbg_req) begin
                    state_nxt = DBG;
                    ret_nxt   = HALTED;
                end else if (start) begin
                    state_nxt = RUN;
                    phase_nxt = 3'd0;
                end else if (step) begin
                    state_nxt = STEP;
                    phase_nxt = 3'd0;
                end
            end
            DBG: begin
                if (ack_done && !bus.dbg_req) begin
                    state_nxt = ret_state;
                    if (ret_state == RUN)
                        phase_nxt = 3'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        ack_done_nxt = (state == DBG) && (state_nxt == DBG) && (ack_done || dbg_hit);
    end

    always_comb begin
        bus.dbg_gnt = 1'b0;
        bus.mem_rd  = bus.cpu_rd;
        bus.mem_wr  = bus.cpu_wr;
        addr_mux    = bus.cpu_addr;
        wdata_mux   = bus.cpu_wdata;
        if (state == DBG) begin
            bus.dbg_gnt = 1'b1;
            bus.mem_rd  = ~bus.dbg_wr & ~ack_done;
            bus.mem_wr  = bus.dbg_wr & ~ack_done;
            addr_mux    = bus.dbg_addr;
            wdata_mux   = bus.dbg_wdata;
        end
        bus.mem_addr  = addr_mux;
        bus.mem_wdata = wdata_mux;
    end

`ifdef CORE_RUN_CTRL_INSTR_CNT_EN
    // Cleared by a fresh start from IDLE, otherwise counts completed instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instr_cnt <= 16'd0;
        else if ((state == IDLE) && !bus.dbg_req && start)
            instr_cnt <= 16'd0;
        else if (boundary)
            instr_cnt <= instr_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed self-checking bench for core_run_ctrl: run, halt, stall, loader arbitration, step and reset.
module tb_core_run_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start, step, stop, core_halt;
    logic [2:0] phase, run_state;
    logic       cpu_en;
`ifdef CORE_RUN_CTRL_INSTR_CNT_EN
    logic [15:0] instr_cnt;
`endif
    int pass_cnt = 0;
    int check_cnt = 0;

    core_run_ctrl_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus ();

    core_run_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .step      (step),
        .stop      (stop),
        .core_halt (core_halt),
        .bus       (bus.slave),
        .phase     (phase),
        .cpu_en    (cpu_en),
        .run_state (run_state)
`ifdef CORE_RUN_CTRL_INSTR_CNT_EN
        ,
        .instr_cnt (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        start = 0; step = 0; stop = 0; core_halt = 0;
        bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_req = 0; bus.dbg_wr = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        bus.mem_ready = 0; bus.mem_rdata = '0;
        #2;
        check_cnt++; if (run_state !== 3'd0) $display("[TB] FAIL reset_state: got %0d want 0", run_state); else pass_cnt++;
        check_cnt++; if (phase !== 3'd0) $display("[TB] FAIL reset_phase: got %0d want 0", phase); else pass_cnt++;
        check_cnt++; if (cpu_en !== 1'b0) $display("[TB] FAIL reset_cpu_en: got %0b want 0", cpu_en); else pass_cnt++;
        check_cnt++; if (bus.dbg_gnt !== 1'b0 || bus.dbg_ack !== 1'b0) $display("[TB] FAIL reset_dbg: got gnt=%0b ack=%0b want 0/0", bus.dbg_gnt, bus.dbg_ack); else pass_cnt++;
        check_cnt++; if (bus.dbg_rdata !== 8'h00) $display("[TB] FAIL reset_rdata: got %0h want 0", bus.dbg_rdata); else pass_cnt++;
        bus.mem_ready = 1;
        tick();
        rst_n = 1;
        tick();
        check_cnt++; if (run_state !== 3'd0) $display("[TB] FAIL idle_after_reset: got %0d want 0", run_state); else pass_cnt++;
    endtask

    task automatic test_run();
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 9; i++) begin
            check_cnt++; if (phase !== 3'(i % 8)) $display("[TB] FAIL run_phase[%0d]: got %0d want %0d", i, phase, i % 8); else pass_cnt++;
            check_cnt++; if (cpu_en !== 1'b1 || run_state !== 3'd1) $display("[TB] FAIL run_en[%0d]: got en=%0b state=%0d want 1/1", i, cpu_en, run_state); else pass_cnt++;
            if (i < 8) tick();
        end
`ifdef CORE_RUN_CTRL_INSTR_CNT_EN
        check_cnt++; if (instr_cnt !== 16'd1) $display("[TB] FAIL run_instr_cnt: got %0d want 1", instr_cnt); else pass_cnt++;
`endif
    endtask

    task automatic test_halt();
        repeat (4) tick();
        core_halt = 1;
        #1;
        check_cnt++; if (phase !== 3'd4 || cpu_en !== 1'b1) $display("[TB] FAIL halt_edge: got phase=%0d en=%0b want 4/1", phase, cpu_en); else pass_cnt++;
        tick();
        core_halt = 0;
        check_cnt++; if (run_state !== 3'd3 || phase !== 3'd4 || cpu_en !== 1'b0) $display("[TB] FAIL halted: got state=%0d phase=%0d en=%0b want 3/4/0", run_state, phase, cpu_en); else pass_cnt++;
        core_halt = 1;
        tick();
        core_halt = 0;
        check_cnt++; if (run_state !== 3'd3 || phase !== 3'd4) $display("[TB] FAIL halt_ignored: got state=%0d phase=%0d want 3/4", run_state, phase); else pass_cnt++;
        start = 1;
        tick();
        start = 0;
        check_cnt++; if (run_state !== 3'd1 || phase !== 3'd0) $display("[TB] FAIL halt_restart: got state=%0d phase=%0d want 1/0", run_state, phase); else pass_cnt++;
    endtask

    task automatic test_stall();
        repeat (2) tick();
        bus.cpu_rd = 1; bus.cpu_addr = 5'h0B; bus.mem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_cnt++; if (phase !== 3'd2 || cpu_en !== 1'b0) $display("[TB] FAIL stall[%0d]: got phase=%0d en=%0b want 2/0", k, phase, cpu_en); else pass_cnt++;
            check_cnt++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 5'h0B) $display("[TB] FAIL stall_mirror[%0d]: got rd=%0b addr=%0h want 1/0b", k, bus.mem_rd, bus.mem_addr); else pass_cnt++;
            tick();
        end
        bus.mem_ready = 1;
        #1;
        check_cnt++; if (cpu_en !== 1'b1 || phase !== 3'd2) $display("[TB] FAIL stall_release: got en=%0b phase=%0d want 1/2", cpu_en, phase); else pass_cnt++;
        tick();
        bus.cpu_rd = 0;
        check_cnt++; if (phase !== 3'd3) $display("[TB] FAIL stall_advance: got %0d want 3", phase); else pass_cnt++;
    endtask

    task automatic test_dbg_write();
        bus.dbg_req = 1; bus.dbg_wr = 1; bus.dbg_addr = 5'h1A; bus.dbg_wdata = 8'h5C;
        for (int p = 3; p <= 7; p++) begin
            #1;
            check_cnt++; if (phase !== 3'(p) || bus.dbg_gnt !== 1'b0) $display("[TB] FAIL dbg_wait[%0d]: got phase=%0d gnt=%0b want %0d/0", p, phase, bus.dbg_gnt, p); else pass_cnt++;
            tick();
        end
        check_cnt++; if (run_state !== 3'd4 || bus.dbg_gnt !== 1'b1 || cpu_en !== 1'b0) $display("[TB] FAIL dbg_grant: got state=%0d gnt=%0b en=%0b want 4/1/0", run_state, bus.dbg_gnt, cpu_en); else pass_cnt++;
        check_cnt++; if (bus.mem_wr !== 1'b1 || bus.mem_rd !== 1'b0 || bus.mem_addr !== 5'h1A || bus.mem_wdata !== 8'h5C) $display("[TB] FAIL dbg_port: got wr=%0b rd=%0b addr=%0h data=%0h want 1/0/1a/5c", bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_wdata); else pass_cnt++;
        check_cnt++; if (bus.dbg_ack !== 1'b0) $display("[TB] FAIL dbg_ack_early: got %0b want 0", bus.dbg_ack); else pass_cnt++;
        tick();
        check_cnt++; if (bus.dbg_ack !== 1'b1 || bus.mem_wr !== 1'b0) $display("[TB] FAIL dbg_ack: got ack=%0b wr=%0b want 1/0", bus.dbg_ack, bus.mem_wr); else pass_cnt++;
        bus.dbg_req = 0;
        tick();
        check_cnt++; if (run_state !== 3'd1 || phase !== 3'd0 || bus.dbg_ack !== 1'b0 || bus.dbg_gnt !== 1'b0) $display("[TB] FAIL dbg_resume: got state=%0d phase=%0d ack=%0b gnt=%0b want 1/0/0/0", run_state, phase, bus.dbg_ack, bus.dbg_gnt); else pass_cnt++;
        tick();
        check_cnt++; if (phase !== 3'd1) $display("[TB] FAIL dbg_resume_adv: got %0d want 1", phase); else pass_cnt++;
    endtask

    task automatic test_stop();
        stop = 1;
        for (int c = 0; c < 20 && run_state != 3'd0; c++) tick();
        stop = 0;
        check_cnt++; if (run_state !== 3'd0 || phase !== 3'd0) $display("[TB] FAIL stop_idle: got state=%0d phase=%0d want 0/0", run_state, phase); else pass_cnt++;
    endtask

    task automatic test_step();
        int en_cnt;
        en_cnt = 0;
        rst_n = 0;
        #2;
        rst_n = 1;
        tick();
`ifdef CORE_RUN_CTRL_INSTR_CNT_EN
        check_cnt++; if (instr_cnt !== 16'd0) $display("[TB] FAIL cnt_reset: got %0d want 0", instr_cnt); else pass_cnt++;
`endif
        core_halt = 1;
        tick();
        core_halt = 0;
        check_cnt++; if (run_state !== 3'd0) $display("[TB] FAIL halt_in_idle: got %0d want 0", run_state); else pass_cnt++;
        step = 1;
        tick();
        step = 0;
        check_cnt++; if (run_state !== 3'd2) $display("[TB] FAIL step_enter: got %0d want 2", run_state); else pass_cnt++;
        for (int c = 0; c < 20 && run_state != 3'd0; c++) begin
            if (cpu_en) en_cnt++;
            tick();
        end
        check_cnt++; if (en_cnt != 8) $display("[TB] FAIL step_cycles: got %0d want 8", en_cnt); else pass_cnt++;
        check_cnt++; if (run_state !== 3'd0 || phase !== 3'd0) $display("[TB] FAIL step_done: got state=%0d phase=%0d want 0/0", run_state, phase); else pass_cnt++;
`ifdef CORE_RUN_CTRL_INSTR_CNT_EN
        check_cnt++; if (instr_cnt !== 16'd1) $display("[TB] FAIL step_cnt: got %0d want 1", instr_cnt); else pass_cnt++;
`endif
    endtask

    task automatic test_dbg_read();
        bus.dbg_req = 1; bus.dbg_wr = 0; bus.dbg_addr = 5'h03; bus.mem_rdata = 8'hA7;
        bus.mem_ready = 0; start = 1;
        #1;
        check_cnt++; if (bus.dbg_gnt !== 1'b0 || run_state !== 3'd0) $display("[TB] FAIL rd_pre: got gnt=%0b state=%0d want 0/0", bus.dbg_gnt, run_state); else pass_cnt++;
        tick();
        check_cnt++; if (run_state !== 3'd4 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 5'h03) $display("[TB] FAIL rd_grant: got state=%0d rd=%0b addr=%0h want 4/1/3", run_state, bus.mem_rd, bus.mem_addr); else pass_cnt++;
        tick();
        check_cnt++; if (bus.dbg_ack !== 1'b0 || bus.mem_rd !== 1'b1) $display("[TB] FAIL rd_wait: got ack=%0b rd=%0b want 0/1", bus.dbg_ack, bus.mem_rd); else pass_cnt++;
        bus.mem_ready = 1;
        tick();
        bus.mem_rdata = 8'h00;
        check_cnt++; if (bus.dbg_ack !== 1'b1 || bus.dbg_rdata !== 8'hA7) $display("[TB] FAIL rd_ack: got ack=%0b data=%0h want 1/a7", bus.dbg_ack, bus.dbg_rdata); else pass_cnt++;
        check_cnt++; if (bus.mem_rd !== 1'b0) $display("[TB] FAIL rd_strobe_drop: got %0b want 0", bus.mem_rd); else pass_cnt++;
        bus.dbg_req = 0;
        tick();
        check_cnt++; if (run_state !== 3'd0 || bus.dbg_ack !== 1'b0 || bus.dbg_rdata !== 8'hA7) $display("[TB] FAIL rd_return: got state=%0d ack=%0b data=%0h want 0/0/a7", run_state, bus.dbg_ack, bus.dbg_rdata); else pass_cnt++;
        tick();
        start = 0;
        check_cnt++; if (run_state !== 3'd1 || phase !== 3'd0) $display("[TB] FAIL rd_deferred_start: got state=%0d phase=%0d want 1/0", run_state, phase); else pass_cnt++;
`ifdef CORE_RUN_CTRL_INSTR_CNT_EN
        check_cnt++; if (instr_cnt !== 16'd0) $display("[TB] FAIL cnt_clear: got %0d want 0", instr_cnt); else pass_cnt++;
`endif
    endtask

    task automatic test_back_to_back();
        repeat (2) tick();
        core_halt = 1;
        tick();
        core_halt = 0;
        bus.dbg_req = 1; bus.dbg_wr = 0; bus.dbg_addr = 5'h07; bus.mem_rdata = 8'h3C;
        tick();
        check_cnt++; if (run_state !== 3'd4 || phase !== 3'd2) $display("[TB] FAIL hdbg_grant: got state=%0d phase=%0d want 4/2", run_state, phase); else pass_cnt++;
        tick();
        check_cnt++; if (bus.dbg_ack !== 1'b1 || bus.dbg_rdata !== 8'h3C) $display("[TB] FAIL hdbg_ack: got ack=%0b data=%0h want 1/3c", bus.dbg_ack, bus.dbg_rdata); else pass_cnt++;
        bus.dbg_req = 0;
        tick();
        check_cnt++; if (run_state !== 3'd3 || phase !== 3'd2) $display("[TB] FAIL hdbg_return: got state=%0d phase=%0d want 3/2", run_state, phase); else pass_cnt++;
        start = 1;
        tick();
        start = 0;
        repeat (7) tick();
        check_cnt++; if (phase !== 3'd7 || run_state !== 3'd1) $display("[TB] FAIL sd_phase7: got phase=%0d state=%0d want 7/1", phase, run_state); else pass_cnt++;
        stop = 1; bus.dbg_req = 1; bus.dbg_wr = 1; bus.dbg_addr = 5'h10; bus.dbg_wdata = 8'h99;
        tick();
        stop = 0;
        check_cnt++; if (run_state !== 3'd4 || bus.mem_wr !== 1'b1) $display("[TB] FAIL sd_dbg_first: got state=%0d wr=%0b want 4/1", run_state, bus.mem_wr); else pass_cnt++;
        tick();
        bus.dbg_req = 0;
        tick();
        check_cnt++; if (run_state !== 3'd0 || phase !== 3'd0) $display("[TB] FAIL sd_return_idle: got state=%0d phase=%0d want 0/0", run_state, phase); else pass_cnt++;
    endtask

    task automatic test_reset_mid_access();
        bus.dbg_req = 1; bus.dbg_wr = 1; bus.mem_ready = 0;
        tick();
        check_cnt++; if (bus.mem_wr !== 1'b1) $display("[TB] FAIL mid_access_wr: got %0b want 1", bus.mem_wr); else pass_cnt++;
        rst_n = 0;
        #1;
        check_cnt++; if (bus.mem_wr !== 1'b0 || bus.dbg_gnt !== 1'b0 || run_state !== 3'd0) $display("[TB] FAIL mid_reset_drop: got wr=%0b gnt=%0b state=%0d want 0/0/0", bus.mem_wr, bus.dbg_gnt, run_state); else pass_cnt++;
        bus.mem_ready = 1;
        tick();
        check_cnt++; if (bus.dbg_ack !== 1'b0) $display("[TB] FAIL mid_reset_ack: got %0b want 0", bus.dbg_ack); else pass_cnt++;
        bus.dbg_req = 0;
        rst_n = 1;
        tick();
        check_cnt++; if (run_state !== 3'd0) $display("[TB] FAIL mid_reset_idle: got %0d want 0", run_state); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_run();
        test_halt();
        test_stall();
        test_dbg_write();
        test_stop();
        test_step();
        test_dbg_read();
        test_back_to_back();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
